// File: rtl/pluto_epp_pkg.sv
// ---------------------------------------------------------------------------
// pluto_epp_pkg : shared types and constants for the EPP host-bus controller
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pluto_epp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ACT   = 2'd2,
    ST_HOLD  = 2'd3
  } epp_state_t;

  localparam int          ADDR_W         = 5;
  localparam int          IDX_W          = 3;
  localparam logic [4:0]  ADDR_CTRL      = 5'd31;
  localparam logic [15:0] WDOG_CLEAR_KEY = 16'hA55A;
  localparam logic [1:0]  BYTE_LANE0     = 2'd0;

endpackage

`default_nettype wire

// File: rtl/pluto_epp_if.sv
// ---------------------------------------------------------------------------
// pluto_epp_if : parallel-port EPP pin bundle (host = master, FPGA = slave)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pluto_epp_if;
  logic       nWrite;
  logic       nAddrStr;
  logic       nDataStr;
  logic       nWait;
  logic [7:0] pport_din;
  logic [7:0] pport_dout;
  logic       pport_oe;

  modport master (
    output nWrite, nAddrStr, nDataStr, pport_din,
    input  nWait, pport_dout, pport_oe
  );

  modport slave (
    input  nWrite, nAddrStr, nDataStr, pport_din,
    output nWait, pport_dout, pport_oe
  );
endinterface

`default_nettype wire

// File: rtl/epp_strobe_sync.sv
// ---------------------------------------------------------------------------
// epp_strobe_sync : 2-flop synchronizer and start-of-strobe detect for EPP pins
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module epp_strobe_sync (
  input  logic clk,
  input  logic nReset,
  input  logic nWrite,
  input  logic nAddrStr,
  input  logic nDataStr,
  output logic addr_act,
  output logic host_wr,
  output logic strobe_act,
  output logic strobe_rise
);

  logic [1:0] r_addr_sync;
  logic [1:0] r_data_sync;
  logic [1:0] r_wr_sync;
  logic       r_act_d;

  // Pins idle high, so the synchronizers reset to the inactive level.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_addr_sync <= 2'b11;
      r_data_sync <= 2'b11;
      r_wr_sync   <= 2'b11;
      r_act_d     <= 1'b0;
    end else begin
      r_addr_sync <= {r_addr_sync[0], nAddrStr};
      r_data_sync <= {r_data_sync[0], nDataStr};
      r_wr_sync   <= {r_wr_sync[0], nWrite};
      r_act_d     <= strobe_act;
    end
  end

  assign addr_act    = ~r_addr_sync[1];
  assign host_wr     = ~r_wr_sync[1];
  assign strobe_act  = ~r_addr_sync[1] | ~r_data_sync[1];
  assign strobe_rise = strobe_act & ~r_act_d;

endmodule

`default_nettype wire

// File: rtl/pluto_epp_ctrl.sv
// ---------------------------------------------------------------------------
// pluto_epp_ctrl : EPP strobes to auto-incrementing register access + watchdog
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pluto_epp_ctrl
  import pluto_epp_pkg::*;
#(
  parameter int NREG_W    = 5,
  parameter int NREG_R    = 5,
  parameter int SETUP_CYC = 1,
  parameter int WDOG_W    = 20
) (
  input  logic              clk,
  input  logic              nReset,
  pluto_epp_if.slave        epp,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [15:0]       wr_data,
  output logic              rd_req,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [31:0]       rd_data,
  input  logic [WDOG_W-1:0] wdog_timeout,
  output logic              wdog_trip,
  output logic              out_enable
);

  localparam int                  c_setup_cw   = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [c_setup_cw-1:0] c_setup_last = c_setup_cw'(SETUP_CYC - 1);

  epp_state_t              r_state;
  epp_state_t              w_state_nxt;
  logic [c_setup_cw-1:0]   r_setup_cnt;
  logic [ADDR_W-1:0]       r_addr;
  logic [7:0]              r_lowbyte;
  logic [31:0]             r_snap;
  logic [7:0]              r_dout;
  logic                    r_cyc_addr;
  logic                    r_cyc_rd;
  logic                    r_armed;
  logic                    r_trip;
  logic [WDOG_W-1:0]       r_wdog_cnt;

  logic        w_addr_act;
  logic        w_host_wr;
  logic        w_strobe_act;
  logic        w_strobe_rise;
  logic        w_in_act;
  logic        w_data_wr;
  logic        w_do_wr;
  logic        w_key_ok;
  logic        w_hold_exit;
  logic [15:0] w_word_in;
  logic [31:0] w_snap_nxt;
  logic [31:0] w_snap_src;
  logic [7:0]  w_snap_byte;

  epp_strobe_sync u_sync (
    .clk         (clk),
    .nReset      (nReset),
    .nWrite      (epp.nWrite),
    .nAddrStr    (epp.nAddrStr),
    .nDataStr    (epp.nDataStr),
    .addr_act    (w_addr_act),
    .host_wr     (w_host_wr),
    .strobe_act  (w_strobe_act),
    .strobe_rise (w_strobe_rise)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_strobe_rise) w_state_nxt = ST_SETUP;
      ST_SETUP: begin
        if (!w_strobe_act)                    w_state_nxt = ST_IDLE;
        else if (r_setup_cnt == c_setup_last) w_state_nxt = ST_ACT;
      end
      ST_ACT:   w_state_nxt = ST_HOLD;
      ST_HOLD:  if (!w_strobe_act) w_state_nxt = ST_IDLE;
    endcase
  end

  // Access decode is only meaningful in ACT; the address strobe wins a tie.
  always_comb begin
    w_in_act    = (r_state == ST_ACT);
    w_data_wr   = w_in_act & ~w_addr_act & w_host_wr;
    w_word_in   = {epp.pport_din, r_lowbyte};
    w_do_wr     = w_data_wr & r_addr[0] & (int'(r_addr[4:1]) < NREG_W);
    w_key_ok    = w_data_wr & (r_addr == ADDR_CTRL) & (w_word_in == WDOG_CLEAR_KEY);
    rd_req      = w_in_act & ~w_addr_act & ~w_host_wr & (r_addr[1:0] == BYTE_LANE0);
    w_snap_nxt  = (int'(rd_idx) < NREG_R) ? rd_data : 32'd0;
    w_snap_src  = rd_req ? w_snap_nxt : r_snap;
    w_snap_byte = w_snap_src[{r_addr[1:0], 3'b000} +: 8];
    w_hold_exit = (r_state == ST_HOLD) & ~w_strobe_act;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_setup_cnt <= '0;
      r_addr      <= '0;
      r_lowbyte   <= '0;
      r_snap      <= '0;
      r_dout      <= '0;
      r_cyc_addr  <= 1'b0;
      r_cyc_rd    <= 1'b0;
    end else begin
      if (r_state != ST_SETUP)            r_setup_cnt <= '0;
      else if (r_setup_cnt != c_setup_last) r_setup_cnt <= r_setup_cnt + 1'b1;

      if (w_in_act) begin
        r_cyc_addr <= w_addr_act;
        r_cyc_rd   <= ~w_host_wr;
      end

      if (w_in_act & w_addr_act & w_host_wr)
        r_addr <= epp.pport_din[ADDR_W-1:0];
      else if (w_hold_exit & ~r_cyc_addr)
        r_addr <= r_addr + 1'b1;

      if (w_data_wr & ~r_addr[0]) r_lowbyte <= epp.pport_din;
      if (rd_req)                 r_snap    <= w_snap_nxt;

      // Read data is registered in ACT so it is stable across all of HOLD.
      if (w_in_act & ~w_host_wr)
        r_dout <= w_addr_act ? {3'b000, r_addr} : w_snap_byte;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wdog_cnt <= '0;
      r_trip     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      if (w_do_wr)              r_wdog_cnt <= '0;
      else if (~&r_wdog_cnt)    r_wdog_cnt <= r_wdog_cnt + 1'b1;

      if (w_key_ok)
        r_trip <= 1'b0;
      else if (~w_do_wr && (wdog_timeout != '0) && (r_wdog_cnt == wdog_timeout))
        r_trip <= 1'b1;

      if (w_do_wr) r_armed <= 1'b1;
    end
  end

  assign wr_en          = w_do_wr;
  assign wr_idx         = w_do_wr ? r_addr[3:1] : '0;
  assign wr_data        = w_do_wr ? w_word_in : '0;
  assign rd_idx         = r_addr[4:2];
  assign wdog_trip      = r_trip;
  assign out_enable     = r_armed & ~r_trip;
  assign epp.nWait      = (r_state != ST_HOLD);
  assign epp.pport_oe   = r_cyc_rd & (r_state == ST_HOLD);
  assign epp.pport_dout = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_pluto_epp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pluto_epp_ctrl : self-checking bench for the EPP host-bus controller
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pluto_epp_ctrl;

  logic        clk = 1'b0;
  logic        nReset;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic [19:0] wdog_timeout;
  logic        wdog_trip;
  logic        out_enable;
  logic [31:0] rd_mem [8];

  always #5 clk = ~clk;

  pluto_epp_if epp ();

  pluto_epp_ctrl dut (
    .clk          (clk),
    .nReset       (nReset),
    .epp          (epp),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .wdog_timeout (wdog_timeout),
    .wdog_trip    (wdog_trip),
    .out_enable   (out_enable)
  );

  assign rd_data = rd_mem[rd_idx];

  typedef struct {
    bit          is_addr;
    bit          is_wr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    int          exp_wr;
    logic [2:0]  exp_idx;
    logic [15:0] exp_data;
    int          exp_rd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_rd = 0;
  int last_wr_cyc = 0;
  logic [2:0]  last_widx;
  logic [15:0] last_wdata;

  logic [7:0] g_dout;
  logic       g_oe;
  int         g_dwr, g_drd, g_la, g_lr;
  int         n0, lim, t;
  bit         ack_seen;

  int          ma, sel, ewr, erd;
  logic [7:0]  mlb, d, edout;
  logic [31:0] msnap;
  logic [2:0]  eidx;
  logic [15:0] edat;
  bit          ia, iw;

  vec_t tbl[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      n_wr++;
      last_widx   = wr_idx;
      last_wdata  = wr_data;
      last_wr_cyc = cyc;
    end
    if (rd_req === 1'b1) n_rd++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t aw(input logic [7:0] a);
    vec_t v = '{1'b1, 1'b1, a, 8'h00, 0, 3'd0, 16'h0, 0};
    return v;
  endfunction
  function automatic vec_t ar(input logic [7:0] e);
    vec_t v = '{1'b1, 1'b0, 8'h00, e, 0, 3'd0, 16'h0, 0};
    return v;
  endfunction
  function automatic vec_t dw(input logic [7:0] x, input int n, input logic [2:0] i, input logic [15:0] w);
    vec_t v = '{1'b0, 1'b1, x, 8'h00, n, i, w, 0};
    return v;
  endfunction
  function automatic vec_t dr(input logic [7:0] e, input int n);
    vec_t v = '{1'b0, 1'b0, 8'h00, e, 0, 3'd0, 16'h0, n};
    return v;
  endfunction

  task automatic do_reset(input logic [19:0] tmo);
    nReset = 1'b0;
    epp.nAddrStr = 1'b1;
    epp.nDataStr = 1'b1;
    epp.nWrite = 1'b1;
    epp.pport_din = 8'h00;
    wdog_timeout = tmo;
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One host EPP cycle; returns the HOLD-time data plus commit/snapshot deltas.
  task automatic xfer(input bit is_addr, input bit is_wr, input logic [7:0] din,
                      output logic [7:0] dout, output logic oe, output int dwr,
                      output int drd, output int lat_ack, output int lat_rel);
    int wr0, rd0;
    @(negedge clk);
    wr0 = n_wr;
    rd0 = n_rd;
    epp.nWrite = ~is_wr;
    epp.pport_din = din;
    @(negedge clk);
    if (is_addr) epp.nAddrStr = 1'b0;
    else         epp.nDataStr = 1'b0;
    lat_ack = 0;
    do begin @(negedge clk); lat_ack++; end while (epp.nWait !== 1'b0 && lat_ack < 20);
    dout = epp.pport_dout;
    oe   = epp.pport_oe;
    epp.nAddrStr = 1'b1;
    epp.nDataStr = 1'b1;
    lat_rel = 0;
    do begin @(negedge clk); lat_rel++; end while (epp.nWait !== 1'b1 && lat_rel < 20);
    repeat (2) @(negedge clk);
    dwr = n_wr - wr0;
    drd = n_rd - rd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 4; i++) rd_mem[i] = $urandom;
    rd_mem[4] = 32'hDEADBEEF;
    for (int i = 5; i < 8; i++) rd_mem[i] = 32'hFFFFFFFF;

    do_reset(20'd0);
    epp.pport_din = 8'hC3;
    @(negedge clk);
    check("rst_nwait", epp.nWait, 1);
    check("rst_oe", epp.pport_oe, 0);
    check("rst_dout", epp.pport_dout, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_trip", wdog_trip, 0);
    check("rst_out_en", out_enable, 0);

    tbl.push_back(aw(8'h00));
    tbl.push_back(dw(8'h34, 0, 3'd0, 16'h0));
    tbl.push_back(dw(8'h12, 1, 3'd0, 16'h1234));
    tbl.push_back(ar(8'h02));
    tbl.push_back(aw(8'h10));
    tbl.push_back(dr(8'hEF, 1));
    tbl.push_back(dr(8'hBE, 0));
    tbl.push_back(dr(8'hAD, 0));
    tbl.push_back(dr(8'hDE, 0));
    tbl.push_back(ar(8'h14));
    tbl.push_back(aw(8'h0A));
    tbl.push_back(dw(8'h77, 0, 3'd0, 16'h0));
    tbl.push_back(dw(8'h66, 0, 3'd0, 16'h0));
    tbl.push_back(aw(8'h0D));
    tbl.push_back(dw(8'h99, 0, 3'd0, 16'h0));
    tbl.push_back(aw(8'h09));
    tbl.push_back(dw(8'h88, 1, 3'd4, 16'h8877));
    tbl.push_back(aw(8'h1C));
    tbl.push_back(dr(8'h00, 1));
    tbl.push_back(aw(8'h1F));
    tbl.push_back(dr(8'h00, 0));
    tbl.push_back(ar(8'h00));

    foreach (tbl[i]) begin
      xfer(tbl[i].is_addr, tbl[i].is_wr, tbl[i].din, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
      check($sformatf("row%0d ack_latency", i), g_la, 5);
      check($sformatf("row%0d release_latency", i), g_lr, 3);
      check($sformatf("row%0d wr_en_count", i), g_dwr, tbl[i].exp_wr);
      check($sformatf("row%0d rd_req_count", i), g_drd, tbl[i].exp_rd);
      check($sformatf("row%0d pport_oe", i), g_oe, {31'd0, ~tbl[i].is_wr});
      if (!tbl[i].is_wr) check($sformatf("row%0d read_byte", i), g_dout, tbl[i].exp_dout);
      if (tbl[i].exp_wr != 0) begin
        check($sformatf("row%0d wr_idx", i), last_widx, tbl[i].exp_idx);
        check($sformatf("row%0d wr_data", i), last_wdata, tbl[i].exp_data);
      end
    end
    check("armed_out_enable", out_enable, 1);

    // Strobe too short to survive the setup window.
    xfer(1'b1, 1'b1, 8'h01, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    n0 = n_wr;
    @(negedge clk);
    epp.nWrite = 1'b0;
    epp.pport_din = 8'hAB;
    @(negedge clk);
    epp.nDataStr = 1'b0;
    @(negedge clk);
    epp.nDataStr = 1'b1;
    ack_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (epp.nWait === 1'b0) ack_seen = 1'b1;
    end
    check("short_pulse_ack", ack_seen, 0);
    check("short_pulse_wr_en", n_wr - n0, 0);
    xfer(1'b1, 1'b0, 8'h00, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    check("short_pulse_addr", g_dout, 8'h01);

    // Randomized traffic against a transaction-level model.
    do_reset(20'd0);
    for (int i = 0; i < 8; i++) rd_mem[i] = $urandom;
    ma = 0;
    mlb = 8'h00;
    msnap = 32'h0;
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 99);
      d = 8'($urandom);
      ewr = 0; erd = 0; eidx = 3'd0; edat = 16'h0; edout = 8'h00;
      if (sel < 20) begin
        ia = 1'b1; iw = 1'b1;
      end else if (sel < 35) begin
        ia = 1'b1; iw = 1'b0;
        edout = 8'(ma);
      end else if (sel < 70) begin
        ia = 1'b0; iw = 1'b1;
        if (ma % 2 == 0) mlb = d;
        else if (ma / 2 < 5) begin
          ewr = 1;
          eidx = 3'(ma / 2);
          edat = {d, mlb};
        end
        ma = (ma + 1) % 32;
      end else begin
        ia = 1'b0; iw = 1'b0;
        if (ma % 4 == 0) begin
          erd = 1;
          msnap = (ma / 4 < 5) ? rd_mem[ma / 4] : 32'h0;
        end
        edout = 8'((msnap >> (8 * (ma % 4))) & 32'hFF);
        ma = (ma + 1) % 32;
      end
      xfer(ia, iw, d, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
      if (ia && iw) ma = d % 32;
      check($sformatf("rnd%0d wr_en_count", k), g_dwr, ewr);
      check($sformatf("rnd%0d rd_req_count", k), g_drd, erd);
      if (!iw) check($sformatf("rnd%0d read_byte", k), g_dout, edout);
      if (ewr != 0) begin
        check($sformatf("rnd%0d wr_idx", k), last_widx, eidx);
        check($sformatf("rnd%0d wr_data", k), last_wdata, edat);
      end
    end

    // Asynchronous reset while a low-byte write sits in HOLD.
    do_reset(20'd0);
    xfer(1'b1, 1'b1, 8'h00, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    n0 = n_wr;
    @(negedge clk);
    epp.nWrite = 1'b0;
    epp.pport_din = 8'h5C;
    @(negedge clk);
    epp.nDataStr = 1'b0;
    lim = 0;
    do begin @(negedge clk); lim++; end while (epp.nWait !== 1'b0 && lim < 20);
    check("midrst_hold_reached", epp.nWait, 0);
    #2 nReset = 1'b0;
    #1;
    check("midrst_nwait", epp.nWait, 1);
    check("midrst_oe", epp.pport_oe, 0);
    epp.nDataStr = 1'b1;
    @(negedge clk);
    nReset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_wr_en", n_wr - n0, 0);
    check("midrst_out_enable", out_enable, 0);
    xfer(1'b1, 1'b0, 8'h00, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    check("midrst_addr", g_dout, 8'h00);
    xfer(1'b1, 1'b1, 8'h01, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'h12, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    check("midrst_lowbyte_cleared", last_wdata, 16'h1200);

    // Watchdog trips 100 idle cycles after the last commit.
    do_reset(20'd100);
    xfer(1'b1, 1'b1, 8'h00, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'h01, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'h00, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    check("wdog_write_commit", g_dwr, 1);
    t = last_wr_cyc + 101;
    lim = 0;
    while (cyc < t && lim < 400) begin @(negedge clk); lim++; end
    check("wdog_before_trip", wdog_trip, 0);
    check("wdog_before_out_en", out_enable, 1);
    @(negedge clk);
    check("wdog_trip", wdog_trip, 1);
    check("wdog_trip_out_en", out_enable, 0);
    xfer(1'b1, 1'b1, 8'h1E, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'h5A, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'hA4, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    check("wdog_bad_key_no_wr", g_dwr, 0);
    check("wdog_bad_key_trip", wdog_trip, 1);
    xfer(1'b1, 1'b1, 8'h1E, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'h5A, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    xfer(1'b0, 1'b1, 8'hA5, g_dout, g_oe, g_dwr, g_drd, g_la, g_lr);
    check("wdog_key_no_wr", g_dwr, 0);
    check("wdog_key_clears_trip", wdog_trip, 0);
    check("wdog_key_out_en", out_enable, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
